// File: rtl/issue_pkg.sv
// Shared issue-stage types: branch ID width, bid pool size, tag FSM states
// and the age helper used by every structure that orders bids against tail.
package issue_pkg;

    localparam int BID_W   = 3;
    localparam int NUM_BID = 2 ** BID_W;

    typedef logic [BID_W-1:0] bid_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } tag_state_e;

    // Distance from the oldest outstanding bid; wraps naturally in BID_W bits.
    function automatic bid_t bid_age(input bid_t bid, input bid_t tail);
        return bid - tail;
    endfunction

endpackage

// File: rtl/bid_age_cmp.sv
// Age comparator: a_older is set when bid_a is strictly older than bid_b,
// both measured from the current tail. Shared with the issue-queue flush logic.
module bid_age_cmp
    import issue_pkg::*;
(
    input  bid_t bid_a,
    input  bid_t bid_b,
    input  bid_t tail,
    output logic a_older
);

    assign a_older = bid_age(bid_a, tail) < bid_age(bid_b, tail);

endmodule

// File: rtl/branch_tag_ctrl.sv
// Branch ID pool: dual in-order allocation, resolve/retire, and mispredict
// flush sequencing. Optional statistics outputs under BRANCH_TAG_STATS_EN.
module branch_tag_ctrl
    import issue_pkg::*;
#(
    parameter int FLUSH_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_1_req,
    input  logic               alloc_2_req,
    output logic               alloc_1_gnt,
    output logic               alloc_2_gnt,
    output logic [BID_W-1:0]   alloc_1_bid,
    output logic [BID_W-1:0]   alloc_2_bid,
    input  logic               resolve_vld,
    input  logic [BID_W-1:0]   resolve_bid,
    input  logic               resolve_mispredict,
    output logic               flush_en,
    output logic [BID_W-1:0]   flush_id,
    output logic               branch_full,
    output logic [NUM_BID-1:0] bid_busy
`ifdef BRANCH_TAG_STATS_EN
    ,
    output logic [15:0]        mispredict_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    localparam logic [BID_W:0] NUM_C = (BID_W + 1)'(NUM_BID);
    localparam logic [BID_W:0] ONE   = (BID_W + 1)'(1);
    localparam logic [BID_W:0] TWO   = (BID_W + 1)'(2);

    bid_t               head_reg, head_next;
    bid_t               tail_reg, tail_next;
    bid_t               flush_id_reg;
    logic [BID_W:0]     count_reg, count_next;
    logic [NUM_BID-1:0] busy_reg, busy_next;
    logic [NUM_BID-1:0] resolved_reg, resolved_next;
    tag_state_e         state_reg, state_next;
    logic [3:0]         stall_reg, stall_next;
    logic               flush_en_reg;
    logic               branch_full_reg;

    logic               mp_raw, mp_acc, cr_acc, rb_older, retire, gnt_ok;
    logic [BID_W:0]     free_now, need_2;
    bid_t               mp_age;
    logic [NUM_BID-1:0] younger;

    // A mispredict during FLUSH only counts if it is older than the one in flight.
    bid_age_cmp u_flush_cmp (
        .bid_a   (resolve_bid),
        .bid_b   (flush_id_reg),
        .tail    (tail_reg),
        .a_older (rb_older)
    );

    assign mp_raw   = resolve_vld & resolve_mispredict & busy_reg[resolve_bid];
    assign mp_acc   = mp_raw & ((state_reg == RUN) | rb_older);
    assign cr_acc   = resolve_vld & ~resolve_mispredict & busy_reg[resolve_bid];
    assign retire   = busy_reg[tail_reg] & resolved_reg[tail_reg];
    assign free_now = NUM_C - count_reg;
    assign need_2   = alloc_1_req ? TWO : ONE;
    assign gnt_ok   = rst & (state_reg == RUN) & ~mp_raw;

    assign alloc_1_gnt = gnt_ok & alloc_1_req & (free_now >= ONE);
    assign alloc_2_gnt = gnt_ok & alloc_2_req & (free_now >= need_2)
                         & (alloc_1_gnt | ~alloc_1_req);
    assign alloc_1_bid = head_reg;
    assign alloc_2_bid = alloc_1_req ? head_reg + bid_t'(1) : head_reg;

    assign mp_age = bid_age(resolve_bid, tail_reg);

    for (genvar gi = 0; gi < NUM_BID; gi++) begin : g_younger
        assign younger[gi] = bid_age(bid_t'(gi), tail_reg) > mp_age;
    end

    always_comb begin
        busy_next     = busy_reg;
        resolved_next = resolved_reg;
        tail_next     = tail_reg;
        head_next     = head_reg + bid_t'(alloc_1_gnt) + bid_t'(alloc_2_gnt);
        if (alloc_1_gnt) begin
            busy_next[alloc_1_bid]     = 1'b1;
            resolved_next[alloc_1_bid] = 1'b0;
        end
        if (alloc_2_gnt) begin
            busy_next[alloc_2_bid]     = 1'b1;
            resolved_next[alloc_2_bid] = 1'b0;
        end
        if (cr_acc) begin
            resolved_next[resolve_bid] = 1'b1;
        end
        if (retire) begin
            busy_next[tail_reg]     = 1'b0;
            resolved_next[tail_reg] = 1'b0;
            tail_next               = tail_reg + bid_t'(1);
        end
        // The mispredicted branch itself is done; it retires once it reaches tail.
        if (mp_acc) begin
            busy_next                  = busy_next & ~younger;
            resolved_next              = resolved_next & ~younger;
            resolved_next[resolve_bid] = 1'b1;
            head_next                  = resolve_bid + bid_t'(1);
        end
        count_next = '0;
        for (int i = 0; i < NUM_BID; i++) begin
            count_next = count_next + (BID_W + 1)'(busy_next[i]);
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_next = stall_reg;
        case (state_reg)
            RUN: begin
                if (mp_acc) begin
                    state_next = FLUSH;
                    stall_next = 4'(FLUSH_CYC);
                end
            end
            FLUSH: begin
                if (mp_acc) begin
                    stall_next = 4'(FLUSH_CYC);
                end else if (stall_reg == 4'd0) begin
                    state_next = RUN;
                end else begin
                    stall_next = stall_reg - 4'd1;
                end
            end
            default: begin
                state_next = RUN;
                stall_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            busy_reg        <= '0;
            resolved_reg    <= '0;
            state_reg       <= RUN;
            stall_reg       <= 4'd0;
            flush_en_reg    <= 1'b0;
            flush_id_reg    <= '0;
            branch_full_reg <= 1'b0;
        end else begin
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
            busy_reg        <= busy_next;
            resolved_reg    <= resolved_next;
            state_reg       <= state_next;
            stall_reg       <= stall_next;
            flush_en_reg    <= mp_acc;
            flush_id_reg    <= mp_acc ? resolve_bid : flush_id_reg;
            branch_full_reg <= (NUM_C - count_next) < TWO;
        end
    end

    assign flush_en    = flush_en_reg;
    assign flush_id    = flush_id_reg;
    assign branch_full = branch_full_reg;
    assign bid_busy    = busy_reg;

`ifdef BRANCH_TAG_STATS_EN
    logic [15:0] mispredict_cnt_reg;
    logic [15:0] stall_cnt_reg;
    logic        stall_event;

    assign stall_event = (alloc_1_req & ~alloc_1_gnt) | (alloc_2_req & ~alloc_2_gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict_cnt_reg <= 16'd0;
            stall_cnt_reg      <= 16'd0;
        end else begin
            if (mp_acc && mispredict_cnt_reg != 16'hFFFF) begin
                mispredict_cnt_reg <= mispredict_cnt_reg + 16'd1;
            end
            if (stall_event && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign mispredict_cnt = mispredict_cnt_reg;
    assign stall_cnt      = stall_cnt_reg;
`else
    // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Bench for branch_tag_ctrl: table of hand-derived per-cycle vectors checked
// through an expectation queue, plus reset and reset-during-flush sequences.
module tb_branch_tag_ctrl;
    import issue_pkg::*;

    logic               clk;
    logic               rst;
    logic               alloc_1_req, alloc_2_req;
    logic               alloc_1_gnt, alloc_2_gnt;
    logic [BID_W-1:0]   alloc_1_bid, alloc_2_bid;
    logic               resolve_vld, resolve_mispredict;
    logic [BID_W-1:0]   resolve_bid;
    logic               flush_en;
    logic [BID_W-1:0]   flush_id;
    logic               branch_full;
    logic [NUM_BID-1:0] bid_busy;
`ifdef BRANCH_TAG_STATS_EN
    logic [15:0]        mispredict_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    branch_tag_ctrl #(.FLUSH_CYC(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_1_req        (alloc_1_req),
        .alloc_2_req        (alloc_2_req),
        .alloc_1_gnt        (alloc_1_gnt),
        .alloc_2_gnt        (alloc_2_gnt),
        .alloc_1_bid        (alloc_1_bid),
        .alloc_2_bid        (alloc_2_bid),
        .resolve_vld        (resolve_vld),
        .resolve_bid        (resolve_bid),
        .resolve_mispredict (resolve_mispredict),
        .flush_en           (flush_en),
        .flush_id           (flush_id),
        .branch_full        (branch_full),
        .bid_busy           (bid_busy)
`ifdef BRANCH_TAG_STATS_EN
        ,
        .mispredict_cnt     (mispredict_cnt),
        .stall_cnt          (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rs: pulse reset before this vector. g*/b* are combinational during the
    // cycle; fe/fid/full/busy are the registered values after the edge.
    typedef struct {
        logic       rs;
        logic       a1, a2, rv, rmp;
        logic [2:0] rbid;
        logic       g1, g2;
        logic [2:0] b1, b2;
        logic       fe;
        logic [2:0] fid;
        logic       full;
        logic [7:0] busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic rs, input logic a1, input logic a2,
                                input logic rv, input logic rmp, input logic [2:0] rbid,
                                input logic g1, input logic g2,
                                input logic [2:0] b1, input logic [2:0] b2,
                                input logic fe, input logic [2:0] fid,
                                input logic full, input logic [7:0] busy);
        vec_t v;
        v.rs = rs; v.a1 = a1; v.a2 = a2; v.rv = rv; v.rmp = rmp; v.rbid = rbid;
        v.g1 = g1; v.g2 = g2; v.b1 = b1; v.b2 = b2;
        v.fe = fe; v.fid = fid; v.full = full; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_1_req = 1'b0; alloc_2_req = 1'b0;
        resolve_vld = 1'b0; resolve_mispredict = 1'b0; resolve_bid = '0;
    endtask

    // Entered and left at posedge+1; requests stay high to prove reset gating.
    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        alloc_1_req = 1'b1; alloc_2_req = 1'b1;
        #2;
        chk("rst g1", {31'd0, alloc_1_gnt}, 32'd0);
        chk("rst g2", {31'd0, alloc_2_gnt}, 32'd0);
        chk("rst flush_en", {31'd0, flush_en}, 32'd0);
        chk("rst flush_id", {29'd0, flush_id}, 32'd0);
        chk("rst full", {31'd0, branch_full}, 32'd0);
        chk("rst busy", {24'd0, bid_busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        logic cg1, cg2;
        logic [2:0] cb1, cb2;
        if (v.rs) do_reset();
        sb_q.push_back(v);
        alloc_1_req = v.a1; alloc_2_req = v.a2;
        resolve_vld = v.rv; resolve_mispredict = v.rmp; resolve_bid = v.rbid;
        #1;
        cg1 = alloc_1_gnt; cg2 = alloc_2_gnt; cb1 = alloc_1_bid; cb2 = alloc_2_bid;
        @(posedge clk); #1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d g1", idx), {31'd0, cg1}, {31'd0, e.g1});
        chk($sformatf("v%0d g2", idx), {31'd0, cg2}, {31'd0, e.g2});
        if (e.g1) chk($sformatf("v%0d b1", idx), {29'd0, cb1}, {29'd0, e.b1});
        if (e.g2) chk($sformatf("v%0d b2", idx), {29'd0, cb2}, {29'd0, e.b2});
        chk($sformatf("v%0d flush_en", idx), {31'd0, flush_en}, {31'd0, e.fe});
        chk($sformatf("v%0d flush_id", idx), {29'd0, flush_id}, {29'd0, e.fid});
        chk($sformatf("v%0d full", idx), {31'd0, branch_full}, {31'd0, e.full});
        chk($sformatf("v%0d busy", idx), {24'd0, bid_busy}, {24'd0, e.busy});
        $display("vec %0d: gnt=%b%b bids=%0d,%0d flush_en=%b flush_id=%0d full=%b busy=%b",
                 idx, cg1, cg2, cb1, cb2, flush_en, flush_id, branch_full, bid_busy);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Fill pool in pairs, then resolve out of order and retire in order, then wrap.
        vecs.push_back(mk(1, 1,1,0,0,0, 1,1,0,1, 0,0,0,8'h03));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,2,3, 0,0,0,8'h0F));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,4,5, 0,0,0,8'h3F));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,6,7, 0,0,1,8'hFF));
        vecs.push_back(mk(0, 1,1,0,0,0, 0,0,0,0, 0,0,1,8'hFF));
        vecs.push_back(mk(0, 0,0,1,0,3, 0,0,0,0, 0,0,1,8'hFF));
        vecs.push_back(mk(0, 0,0,1,0,0, 0,0,0,0, 0,0,1,8'hFF));
        vecs.push_back(mk(0, 0,0,1,0,1, 0,0,0,0, 0,0,1,8'hFE));
        vecs.push_back(mk(0, 0,0,1,0,2, 0,0,0,0, 0,0,0,8'hFC));
        vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0, 0,0,0,8'hF8));
        vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0, 0,0,0,8'hF0));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,0,1, 0,0,0,8'hF3));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,2,3, 0,0,1,8'hFF));
        // Mispredict bid 2 with 0..5 outstanding; stall window, then bid 3.
        vecs.push_back(mk(1, 1,1,0,0,0, 1,1,0,1, 0,0,0,8'h03));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,2,3, 0,0,0,8'h0F));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,4,5, 0,0,0,8'h3F));
        vecs.push_back(mk(0, 1,1,1,1,2, 0,0,0,0, 1,2,0,8'h07));
        vecs.push_back(mk(0, 1,1,0,0,0, 0,0,0,0, 0,2,0,8'h07));
        vecs.push_back(mk(0, 1,1,0,0,0, 0,0,0,0, 0,2,0,8'h07));
        vecs.push_back(mk(0, 1,1,0,0,0, 0,0,0,0, 0,2,0,8'h07));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,3,4, 0,2,0,8'h1F));
        // Nested flush: bid 4, then older bid 1; non-busy and equal-age ignored.
        vecs.push_back(mk(1, 1,1,0,0,0, 1,1,0,1, 0,0,0,8'h03));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,2,3, 0,0,0,8'h0F));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,4,5, 0,0,0,8'h3F));
        vecs.push_back(mk(0, 1,1,1,1,4, 0,0,0,0, 1,4,0,8'h1F));
        vecs.push_back(mk(0, 1,1,1,1,1, 0,0,0,0, 1,1,0,8'h03));
        vecs.push_back(mk(0, 1,1,1,1,5, 0,0,0,0, 0,1,0,8'h03));
        vecs.push_back(mk(0, 1,1,1,1,1, 0,0,0,0, 0,1,0,8'h03));
        vecs.push_back(mk(0, 1,1,1,0,0, 0,0,0,0, 0,1,0,8'h03));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,2,3, 0,1,0,8'h0E));
        vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0, 0,1,0,8'h0C));
        // Near-full corners: slot 2 blocked at 1 free, slot-2-only grant at head, none at 0.
        vecs.push_back(mk(1, 1,1,0,0,0, 1,1,0,1, 0,0,0,8'h03));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,2,3, 0,0,0,8'h0F));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,1,4,5, 0,0,0,8'h3F));
        vecs.push_back(mk(0, 1,0,0,0,0, 1,0,6,0, 0,0,1,8'h7F));
        vecs.push_back(mk(0, 1,1,0,0,0, 1,0,7,0, 0,0,1,8'hFF));
        vecs.push_back(mk(0, 0,0,1,0,0, 0,0,0,0, 0,0,1,8'hFF));
        vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0, 0,0,1,8'hFE));
        vecs.push_back(mk(0, 0,1,0,0,0, 0,1,0,0, 0,0,1,8'hFF));
        vecs.push_back(mk(0, 0,1,0,0,0, 0,0,0,0, 0,0,1,8'hFF));

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end
        chk("scoreboard drained", sb_q.size(), 32'd0);

        // Reset asserted while a flush pulse is live clears it without waiting for a clock.
        do_reset();
        alloc_1_req = 1'b1; alloc_2_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        alloc_1_req = 1'b0; alloc_2_req = 1'b0;
        resolve_vld = 1'b1; resolve_mispredict = 1'b1; resolve_bid = 3'd1;
        @(posedge clk); #1;
        idle_inputs();
        chk("midflush pulse", {31'd0, flush_en}, 32'd1);
        chk("midflush busy", {24'd0, bid_busy}, 32'h03);
        rst = 1'b0;
        #1;
        chk("midflush rst flush_en", {31'd0, flush_en}, 32'd0);
        chk("midflush rst flush_id", {29'd0, flush_id}, 32'd0);
        chk("midflush rst busy", {24'd0, bid_busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        alloc_1_req = 1'b1;
        #1;
        chk("post-reset grant", {31'd0, alloc_1_gnt}, 32'd1);
        chk("post-reset bid", {29'd0, alloc_1_bid}, 32'd0);
        @(posedge clk); #1;
        chk("post-reset flush_en", {31'd0, flush_en}, 32'd0);
        $display("reset-in-flush sequence: flush_en=%b busy=%b", flush_en, bid_busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
